// File: rtl/openila_pkg.sv
// Shared definitions for the OpenILA simple-mode codec: codeword tags,
// memory-word width helper and the decompressor state type.
package openila_pkg;

    localparam logic CW_TAG_LITERAL = 1'b0;
    localparam logic CW_TAG_RUN     = 1'b1;

    // Capture memory word = one tag bit plus the sample/count payload.
    function automatic int w_mem(input int w_sample);
        return w_sample + 1;
    endfunction

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } dec_state_e;

endpackage

// File: rtl/openila_decompress.sv
// Expands the simple-mode compressed capture stream into one raw sample per captured cycle.
// Optional sample index output (dout_idx) enabled by `OPENILA_DECOMPRESS_TSTAMP_EN.
//
// state | meaning
// LOAD  | accepting codewords; a literal or the first beat of a run is emitted on accept
// RUN   | replaying prev for the remaining beats of a run word; no codeword accepted
module openila_decompress
    import openila_pkg::*;
#(
    parameter int W_SAMPLE  = 8,
    parameter int W_COUNT   = 8,
    parameter int W_TSTAMP  = 32,
    localparam int W_MEM    = w_mem(W_SAMPLE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [W_MEM-1:0]    cw,
    input  logic                cw_valid,
    output logic                cw_ready,
    output logic [W_SAMPLE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy
`ifdef OPENILA_DECOMPRESS_TSTAMP_EN
    ,
    output logic [W_TSTAMP-1:0] dout_idx
`endif
);

    if (W_COUNT != W_SAMPLE) begin : g_bad_count
        $error("openila_decompress: W_COUNT must equal W_SAMPLE");
    end
    if (W_TSTAMP < 1) begin : g_bad_tstamp
        $error("openila_decompress: W_TSTAMP must be at least 1");
    end

    localparam logic [W_COUNT:0] CTR_ONE  = (W_COUNT+1)'(1);
    localparam logic [W_COUNT:0] CTR_FULL = {1'b1, {W_COUNT{1'b0}}};

    dec_state_e          state_q, state_d;
    logic [W_COUNT:0]    run_ctr_q, run_ctr_d;
    logic [W_SAMPLE-1:0] prev_q, prev_d;
    logic [W_SAMPLE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;

    logic                advance;
    logic                cw_accept;
    logic                cw_is_run;
    logic [W_SAMPLE-1:0] cw_payload;
    logic [W_COUNT:0]    run_len;

    assign advance    = !dout_valid_q || dout_ready;
    assign cw_ready   = (state_q == LOAD) && advance && !clr;
    assign cw_accept  = cw_valid && cw_ready;
    assign cw_is_run  = (cw[W_MEM-1] == CW_TAG_RUN);
    assign cw_payload = cw[W_SAMPLE-1:0];
    // A zero count encodes the longest run the counter field can express.
    assign run_len    = (cw_payload == '0) ? CTR_FULL : {1'b0, cw_payload};

    always_comb begin
        state_d   = state_q;
        run_ctr_d = run_ctr_q;
        prev_d    = prev_q;
        if (clr) begin
            state_d   = LOAD;
            run_ctr_d = '0;
            prev_d    = '0;
        end else if (state_q == LOAD) begin
            if (cw_accept) begin
                if (cw_is_run) begin
                    run_ctr_d = run_len - CTR_ONE;
                    if (run_len != CTR_ONE) begin
                        state_d = RUN;
                    end
                end else begin
                    prev_d = cw_payload;
                end
            end
        end else if (advance) begin
            run_ctr_d = run_ctr_q - CTR_ONE;
            if (run_ctr_q == CTR_ONE) begin
                state_d = LOAD;
            end
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (clr) begin
            dout_valid_d = 1'b0;
        end else if (advance) begin
            if (state_q == RUN) begin
                dout_d       = prev_q;
                dout_valid_d = 1'b1;
            end else if (cw_accept) begin
                dout_d       = cw_is_run ? prev_q : cw_payload;
                dout_valid_d = 1'b1;
            end else begin
                dout_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            run_ctr_q    <= '0;
            prev_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_ctr_q    <= run_ctr_d;
            prev_q       <= prev_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == RUN);

`ifdef OPENILA_DECOMPRESS_TSTAMP_EN
    logic [W_TSTAMP-1:0] dout_idx_q, dout_idx_d;

    always_comb begin
        dout_idx_d = dout_idx_q;
        if (clr) begin
            dout_idx_d = '0;
        end else if (dout_valid_q && dout_ready) begin
            dout_idx_d = dout_idx_q + W_TSTAMP'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_idx_q <= '0;
        end else begin
            dout_idx_q <= dout_idx_d;
        end
    end

    assign dout_idx = dout_idx_q;
`endif

endmodule

// File: tb/tb_openila_decompress.sv
// Directed self-checking bench for openila_decompress (W_SAMPLE=W_COUNT=8, W_TSTAMP=4).
module tb_openila_decompress;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [8:0] cw = '0;
    logic       cw_valid = 1'b0;
    logic       cw_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic       busy;
`ifdef OPENILA_DECOMPRESS_TSTAMP_EN
    logic [3:0] dout_idx;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    openila_decompress #(
        .W_SAMPLE (8),
        .W_COUNT  (8),
        .W_TSTAMP (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .cw         (cw),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
`ifdef OPENILA_DECOMPRESS_TSTAMP_EN
        ,
        .dout_idx   (dout_idx)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int n;
        int bad;
        int k;
        int exp_idx;
        logic acc;
        logic stalled;
        logic [7:0] held;
        logic [8:0] seq [2];

        // reset state
        #12;
        check("rst_dout", dout, 8'h00);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cyc();
        check("idle_valid", dout_valid, 1'b0);
        check("idle_cw_ready", cw_ready, 1'b1);

        // back-to-back literals
        cw = 9'h0A4; cw_valid = 1'b1;
        cyc();
        check("lit1_dout", dout, 8'hA4);
        check("lit1_valid", dout_valid, 1'b1);
        cw = 9'h0B7;
        settle();
        check("lit2_cw_ready", cw_ready, 1'b1);
        cyc();
        check("lit2_dout", dout, 8'hB7);
        check("lit2_valid", dout_valid, 1'b1);
        cw_valid = 1'b0;
        cyc();
        check("lit_drain_valid", dout_valid, 1'b0);

        // literal, run of 3, literal with no bubble
        cw = 9'h05C; cw_valid = 1'b1;
        cyc();
        check("r3_b1", dout, 8'h5C);
        cw = 9'h103;
        settle();
        check("r3_cw_ready_load", cw_ready, 1'b1);
        cyc();
        check("r3_b2", dout, 8'h5C);
        check("r3_b2_valid", dout_valid, 1'b1);
        check("r3_busy_a", busy, 1'b1);
        cw = 9'h0E1;
        settle();
        check("r3_cw_ready_a", cw_ready, 1'b0);
        cyc();
        check("r3_b3", dout, 8'h5C);
        check("r3_busy_b", busy, 1'b1);
        check("r3_cw_ready_b", cw_ready, 1'b0);
        cyc();
        check("r3_b4", dout, 8'h5C);
        check("r3_b4_valid", dout_valid, 1'b1);
        check("r3_busy_end", busy, 1'b0);
        check("r3_cw_ready_end", cw_ready, 1'b1);
        cyc();
        check("r3_next_lit", dout, 8'hE1);
        check("r3_next_lit_valid", dout_valid, 1'b1);
        cw_valid = 1'b0;
        cyc();
        check("r3_drain_valid", dout_valid, 1'b0);

        // run count 0 means 256 copies
        cw = 9'h011; cw_valid = 1'b1;
        cyc();
        check("r256_lit", dout, 8'h11);
        cw = 9'h100;
        cyc();
        cw_valid = 1'b0;
        check("r256_busy", busy, 1'b1);
        n = 0;
        for (int i = 0; i < 300 && dout_valid; i++) begin
            if (dout == 8'h11) n++;
            cyc();
        end
        check("r256_count", n, 256);
        check("r256_end_valid", dout_valid, 1'b0);

        // reset mid-run, then run of 1 straight after reset
        cw = 9'h0AB; cw_valid = 1'b1;
        cyc();
        cw = 9'h180;
        cyc();
        cw_valid = 1'b0;
        cyc();
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", dout_valid, 1'b0);
        check("mid_rst_dout", dout, 8'h00);
        #1;
        rst_n = 1'b1;
        cyc();
        cw = 9'h101; cw_valid = 1'b1;
        settle();
        check("r1_cw_ready", cw_ready, 1'b1);
        cyc();
        cw_valid = 1'b0;
        check("r1_dout", dout, 8'h00);
        check("r1_valid", dout_valid, 1'b1);
        check("r1_busy", busy, 1'b0);
        cyc();
        check("r1_drain_valid", dout_valid, 1'b0);

        // backpressure: dout_ready toggling 1010...
        seq[0] = 9'h033;
        seq[1] = 9'h104;
        k = 0; n = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            dout_ready = (i % 2 == 0);
            cw_valid   = (k < 2);
            cw         = seq[(k < 2) ? k : 1];
            settle();
            acc = cw_valid && cw_ready;
            if (dout_valid && dout_ready) begin
                if (dout == 8'h33) n++;
                else bad++;
            end
            stalled = dout_valid && !dout_ready;
            if (stalled && cw_ready) bad++;
            held = dout;
            cyc();
            if (acc) k++;
            if (stalled && (dout !== held || dout_valid !== 1'b1)) bad++;
        end
        cw_valid = 1'b0;
        dout_ready = 1'b1;
        check("bp_samples", n, 5);
        check("bp_violations", bad, 0);
        check("bp_cw_taken", k, 2);

        // clr during a long run beats a simultaneous codeword
        cw = 9'h077; cw_valid = 1'b1;
        cyc();
        cw = 9'h133;
        cyc();
        check("clr_busy_before", busy, 1'b1);
        clr = 1'b1;
        cw = 9'h0AA;
        settle();
        check("clr_cw_ready", cw_ready, 1'b0);
        cyc();
        clr = 1'b0;
        cw = 9'h102;
        settle();
        check("clr_valid", dout_valid, 1'b0);
        check("clr_busy", busy, 1'b0);
        check("clr_cw_ready_after", cw_ready, 1'b1);
        cyc();
        cw_valid = 1'b0;
        check("clr_r2_b1", dout, 8'h00);
        check("clr_r2_b1_valid", dout_valid, 1'b1);
        check("clr_r2_busy", busy, 1'b1);
        cyc();
        check("clr_r2_b2", dout, 8'h00);
        check("clr_r2_b2_valid", dout_valid, 1'b1);
        check("clr_r2_busy_end", busy, 1'b0);
        cyc();
        check("clr_r2_drain", dout_valid, 1'b0);

`ifdef OPENILA_DECOMPRESS_TSTAMP_EN
        // sample index wraps modulo 16 and is cleared by clr
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("idx_clr0", dout_idx, 4'd0);
        seq[0] = 9'h001;
        seq[1] = 9'h111;
        k = 0; n = 0; exp_idx = 0;
        for (int i = 0; i < 40; i++) begin
            cw_valid = (k < 2);
            cw       = seq[(k < 2) ? k : 1];
            settle();
            acc = cw_valid && cw_ready;
            if (dout_valid) begin
                check("idx_seq", dout_idx, exp_idx);
                exp_idx = (exp_idx + 1) % 16;
                n++;
            end
            cyc();
            if (acc) k++;
        end
        cw_valid = 1'b0;
        check("idx_samples", n, 18);
        check("idx_final", dout_idx, 4'd2);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("idx_clr", dout_idx, 4'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
